// File: rtl/tone_pkg.sv
// Shared types, widths and the half-period clamp for the tone generator.
package tone_pkg;

    localparam int unsigned FREQ_W = 18;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } tone_state_t;

    // Zero means silence; nonzero values below min_half are raised to min_half.
    function automatic logic [FREQ_W-1:0] clamp_half(input logic [FREQ_W-1:0] v,
                                                     input logic [FREQ_W-1:0] min_half);
        logic [FREQ_W-1:0] r;
        r = v;
        if ((v != '0) && (v < min_half)) begin
            r = min_half;
        end
        return r;
    endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Decoder/amplifier-facing signals of the tone generator.
// The octave inputs exist only when TONE_OCTAVE_EN is defined.
interface tone_generator_if;
    import tone_pkg::*;

    logic [FREQ_W-1:0] freqVal;
    logic              audioOut;
    logic              audioSd;
    logic              noteActive;
`ifdef TONE_OCTAVE_EN
    logic              octUp;
    logic              octDown;

    modport master (output freqVal, octUp, octDown,
                    input  audioOut, audioSd, noteActive);
    modport slave  (input  freqVal, octUp, octDown,
                    output audioOut, audioSd, noteActive);
`else
    modport master (output freqVal,
                    input  audioOut, audioSd, noteActive);
    modport slave  (input  freqVal,
                    output audioOut, audioSd, noteActive);
`endif
endinterface

// File: rtl/tone_input_filter.sv
// Debounces the note half-period: a value is committed only after it has held
// for STABLE_CYCLES consecutive cycles; the last stable value wins.
module tone_input_filter
    import tone_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1_000_000,
    parameter int unsigned MIN_HALF      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] freq_val,
    input  logic [FREQ_W-1:0] playing_val,
    input  logic              consume,
    output logic [FREQ_W-1:0] pend_val,
    output logic              pend_valid
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [FREQ_W-1:0] freq_q;
    logic [CNT_W-1:0]  stable_cnt;
    logic              match_c;
    logic              commit_c;
    logic [FREQ_W-1:0] commit_val_c;

    assign match_c      = (freq_val == freq_q);
    assign commit_c     = match_c && (stable_cnt == CNT_W'(STABLE_CYCLES - 1));
    assign commit_val_c = clamp_half(freq_q, FREQ_W'(MIN_HALF));

    // Counter saturates one past the commit point so a held value commits once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_q     <= '0;
            stable_cnt <= '0;
            pend_val   <= '0;
            pend_valid <= 1'b0;
        end else begin
            freq_q <= freq_val;
            if (!match_c) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_W'(STABLE_CYCLES)) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
            // A fresh commit takes priority over the consumer clearing the flag.
            if (commit_c) begin
                pend_val   <= commit_val_c;
                pend_valid <= (commit_val_c != playing_val);
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator with debounced, glitch-free note changes.
// Optional feature macro: TONE_OCTAVE_EN (octave up/down on note load).
module tone_generator
    import tone_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1_000_000,
    parameter int unsigned MIN_HALF      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    tone_generator_if.slave  bus
);

    tone_state_t       state_q,    state_d;
    logic [FREQ_W-1:0] half_cnt_q, half_cnt_d;
    logic [FREQ_W-1:0] cur_half_q, cur_half_d;
    logic [FREQ_W-1:0] cur_src_q,  cur_src_d;
    logic              audio_q,    audio_d;
    logic              sd_q,       sd_d;
    logic              note_q;
    logic [FREQ_W-1:0] pend_val;
    logic              pend_valid;
    logic              consume_c;
    logic              boundary_c;
    logic [FREQ_W-1:0] eff_c;

    tone_input_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .MIN_HALF      (MIN_HALF)
    ) u_filter (
        .clk         (clk),
        .rst_n       (rst_n),
        .freq_val    (bus.freqVal),
        .playing_val (cur_src_q),
        .consume     (consume_c),
        .pend_val    (pend_val),
        .pend_valid  (pend_valid)
    );

`ifdef TONE_OCTAVE_EN
    // Octave shift applied at load time only; doubling saturates at full scale.
    always_comb begin
        eff_c = pend_val;
        if (bus.octUp && !bus.octDown) begin
            eff_c = pend_val >> 1;
        end else if (bus.octDown && !bus.octUp) begin
            eff_c = pend_val[FREQ_W-1] ? {FREQ_W{1'b1}} : (pend_val << 1);
        end
        eff_c = clamp_half(eff_c, FREQ_W'(MIN_HALF));
    end
`else
    assign eff_c = pend_val;
`endif

    assign boundary_c = (half_cnt_q == (cur_half_q - FREQ_W'(1)));

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        cur_half_d = cur_half_q;
        cur_src_d  = cur_src_q;
        audio_d    = audio_q;
        sd_d       = sd_q;
        consume_c  = 1'b0;
        case (state_q)
            IDLE: begin
                audio_d = 1'b0;
                sd_d    = 1'b0;
                if (pend_valid) begin
                    consume_c = 1'b1;
                    if (pend_val != '0) begin
                        cur_half_d = eff_c;
                        cur_src_d  = pend_val;
                        half_cnt_d = '0;
                        audio_d    = 1'b1;
                        sd_d       = 1'b1;
                        state_d    = PLAY;
                    end
                end
            end
            PLAY: begin
                half_cnt_d = half_cnt_q + FREQ_W'(1);
                if (boundary_c) begin
                    half_cnt_d = '0;
                    audio_d    = !audio_q;
                    if (pend_valid) begin
                        consume_c = 1'b1;
                        if (pend_val == '0) begin
                            audio_d   = 1'b0;
                            sd_d      = 1'b0;
                            cur_src_d = '0;
                            state_d   = IDLE;
                        end else begin
                            cur_half_d = eff_c;
                            cur_src_d  = pend_val;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            cur_half_q <= '0;
            cur_src_q  <= '0;
            audio_q    <= 1'b0;
            sd_q       <= 1'b0;
            note_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            cur_half_q <= cur_half_d;
            cur_src_q  <= cur_src_d;
            audio_q    <= audio_d;
            sd_q       <= sd_d;
            note_q     <= (state_d == PLAY);
        end
    end

    assign bus.audioOut   = audio_q;
    assign bus.audioSd    = sd_q;
    assign bus.noteActive = note_q;

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator with STABLE_CYCLES=4, MIN_HALF=2.
module tb_tone_generator;
    import tone_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;

    always #5 clk = ~clk;

    tone_generator_if bus ();

    tone_generator #(
        .STABLE_CYCLES (4),
        .MIN_HALF      (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles until audioOut next changes level; 1000 means no change seen.
    task automatic half_len(output int len);
        logic v;
        v   = bus.audioOut;
        len = 0;
        while (len < 1000) begin
            @(negedge clk);
            len++;
            if (bus.audioOut !== v) break;
        end
    endtask

    task automatic count_edges(input int cycles, output int edges);
        logic v;
        v     = bus.audioOut;
        edges = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.audioOut !== v) edges++;
            v = bus.audioOut;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.freqVal = 18'd10;
`ifdef TONE_OCTAVE_EN
        bus.octUp   = 1'b0;
        bus.octDown = 1'b0;
`endif
        // Reset holds everything low
        repeat (3) @(negedge clk);
        check("rst_audioOut",   32'(bus.audioOut),   32'd0);
        check("rst_audioSd",    32'(bus.audioSd),    32'd0);
        check("rst_noteActive", 32'(bus.noteActive), 32'd0);

        // First note: rise 6 cycles after release, then halves of 10
        rst_n = 1'b1;
        half_len(n); check("t1_first_rise", 32'(n), 32'd6);
        check("t1_audioOut",   32'(bus.audioOut),   32'd1);
        check("t1_audioSd",    32'(bus.audioSd),    32'd1);
        check("t1_noteActive", 32'(bus.noteActive), 32'd1);
        half_len(n); check("t1_half_a", 32'(n), 32'd10);
        half_len(n); check("t1_half_b", 32'(n), 32'd10);

        // Change to 6 at halfCnt=3: current half finishes its 10 cycles
        repeat (3) @(negedge clk);
        bus.freqVal = 18'd6;
        half_len(n); check("t2_rest_of_10", 32'(n), 32'd7);
        half_len(n); check("t2_half6_a", 32'(n), 32'd6);
        half_len(n); check("t2_half6_b", 32'(n), 32'd6);

        // Back to 10: committed mid-half, applied at the next boundary
        bus.freqVal = 18'd10;
        half_len(n); check("t2_last_6", 32'(n), 32'd6);
        half_len(n); check("t2_back10_a", 32'(n), 32'd10);
        half_len(n); check("t2_back10_b", 32'(n), 32'd10);

        // Silence: ends low at the boundary, no further edges
        bus.freqVal = 18'd0;
        half_len(n); check("t3_stop_at_boundary", 32'(n), 32'd10);
        check("t3_audioOut",   32'(bus.audioOut),   32'd0);
        check("t3_audioSd",    32'(bus.audioSd),    32'd0);
        check("t3_noteActive", 32'(bus.noteActive), 32'd0);
        count_edges(40, n); check("t3_no_edges", 32'(n), 32'd0);

        // Restart from IDLE, then a 3-cycle glitch to 20 is ignored
        bus.freqVal = 18'd10;
        half_len(n); check("t4_rise", 32'(n), 32'd6);
        half_len(n); check("t4_half", 32'(n), 32'd10);
        bus.freqVal = 18'd20;
        repeat (3) @(negedge clk);
        bus.freqVal = 18'd10;
        half_len(n); check("t4_glitch_half", 32'(n), 32'd7);
        half_len(n); check("t4_after_a", 32'(n), 32'd10);
        half_len(n); check("t4_after_b", 32'(n), 32'd10);

        // freqVal=1 clamps to 2
        bus.freqVal = 18'd1;
        half_len(n); check("t5_rest_of_10", 32'(n), 32'd10);
        half_len(n); check("t5_clamp_a", 32'(n), 32'd2);
        half_len(n); check("t5_clamp_b", 32'(n), 32'd2);
        half_len(n); check("t5_clamp_c", 32'(n), 32'd2);
        check("t5_high_before_rst", 32'(bus.audioOut), 32'd1);

        // Reset mid-half drops outputs immediately; no resumption after release
        rst_n = 1'b0;
        #1;
        check("t5_rst_audioOut",   32'(bus.audioOut),   32'd0);
        check("t5_rst_audioSd",    32'(bus.audioSd),    32'd0);
        check("t5_rst_noteActive", 32'(bus.noteActive), 32'd0);
        @(negedge clk);
        bus.freqVal = 18'd10;
        rst_n = 1'b1;
        half_len(n); check("t5_restart_rise", 32'(n), 32'd6);
        half_len(n); check("t5_restart_half", 32'(n), 32'd10);

`ifdef TONE_OCTAVE_EN
        // Octave up halves, octave down doubles, doubling saturates
        rst_n = 1'b0;
        bus.octUp = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        half_len(n); check("t6_up_rise", 32'(n), 32'd6);
        half_len(n); check("t6_up_half", 32'(n), 32'd5);
        rst_n = 1'b0;
        bus.octUp   = 1'b0;
        bus.octDown = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        half_len(n); check("t6_down_rise", 32'(n), 32'd6);
        half_len(n); check("t6_down_half", 32'(n), 32'd20);
        rst_n = 1'b0;
        bus.freqVal = 18'h3FFFF;
        @(negedge clk);
        rst_n = 1'b1;
        half_len(n); check("t6_sat_rise", 32'(n), 32'd6);
        check("t6_sat_half", 32'(dut.cur_half_q), 32'h3FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
